// File: rtl/simon_host_serial_if.sv
// simon_host_serial_if: serial command bus between the host adapter and the
// bit-serial SIMON 128/128 core.
//   core_data_in    host->core  serial plaintext/key bit
//   core_data_rdy   host->core  command: 00 idle, 01 pt bit, 10 key bit, 11 run
//   core_debug_port host->core  output select (0 = cipher output)
//   core_cipher_out core->host  serial ciphertext bit
//   core_valid      core->host  ciphertext valid flag
interface simon_host_serial_if;
    logic       core_data_in;
    logic [1:0] core_data_rdy;
    logic       core_debug_port;
    logic       core_cipher_out;
    logic       core_valid;

    modport master (
        output core_data_in,
        output core_data_rdy,
        output core_debug_port,
        input  core_cipher_out,
        input  core_valid
    );

    modport slave (
        input  core_data_in,
        input  core_data_rdy,
        input  core_debug_port,
        output core_cipher_out,
        output core_valid
    );
endinterface

// File: rtl/simon_host_serial.sv
// simon_host_serial: parallel-to-serial host adapter for the SIMON core.
// Ports: clk, reset (sync, active-high); host side start/pt/key in and
// busy/done/ct/timeout_err out; core side through simon_host_serial_if.master.
module simon_host_serial #(
    parameter int BLOCK_BITS  = 128,
    parameter int KEY_BITS    = 128,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BLOCK_BITS-1:0] pt,
    input  logic [KEY_BITS-1:0]   key,
    output logic                  busy,
    output logic                  done,
    output logic [BLOCK_BITS-1:0] ct,
    output logic                  timeout_err,
    simon_host_serial_if.master   core
);

    localparam int MAX_BITS = (BLOCK_BITS > KEY_BITS) ? BLOCK_BITS : KEY_BITS;
    localparam int CW       = $clog2(MAX_BITS);
    localparam int TW       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_PT  = 3'd1;
    localparam logic [2:0] S_LOAD_KEY = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_CAPTURE  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]            state;
    logic [BLOCK_BITS-1:0] pt_sr;
    logic [KEY_BITS-1:0]   key_sr;
    logic [BLOCK_BITS-1:0] cap;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         to_cnt;

    assign core.core_debug_port = 1'b0;

    // Outputs are registered together with the state, so the bit presented
    // to the core is loaded one edge ahead of the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            pt_sr              <= '0;
            key_sr             <= '0;
            cap                <= '0;
            bit_cnt            <= '0;
            to_cnt             <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            ct                 <= '0;
            timeout_err        <= 1'b0;
            core.core_data_in  <= 1'b0;
            core.core_data_rdy <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pt_sr              <= pt >> 1;
                        key_sr             <= key;
                        bit_cnt            <= '0;
                        timeout_err        <= 1'b0;
                        busy               <= 1'b1;
                        core.core_data_in  <= pt[0];
                        core.core_data_rdy <= 2'b01;
                        state              <= S_LOAD_PT;
                    end
                end
                S_LOAD_PT: begin
                    if (bit_cnt == CW'(BLOCK_BITS - 1)) begin
                        bit_cnt            <= '0;
                        key_sr             <= key_sr >> 1;
                        core.core_data_in  <= key_sr[0];
                        core.core_data_rdy <= 2'b10;
                        state              <= S_LOAD_KEY;
                    end else begin
                        bit_cnt           <= bit_cnt + CW'(1);
                        pt_sr             <= pt_sr >> 1;
                        core.core_data_in <= pt_sr[0];
                    end
                end
                S_LOAD_KEY: begin
                    if (bit_cnt == CW'(KEY_BITS - 1)) begin
                        bit_cnt            <= '0;
                        to_cnt             <= '0;
                        core.core_data_in  <= 1'b0;
                        core.core_data_rdy <= 2'b11;
                        state              <= S_RUN;
                    end else begin
                        bit_cnt           <= bit_cnt + CW'(1);
                        key_sr            <= key_sr >> 1;
                        core.core_data_in <= key_sr[0];
                    end
                end
                S_RUN: begin
                    to_cnt <= to_cnt + TW'(1);
                    // valid wins over a timeout landing on the same edge
                    if (core.core_valid) begin
                        cap     <= {core.core_cipher_out, cap[BLOCK_BITS-1:1]};
                        bit_cnt <= '0;
                        state   <= S_CAPTURE;
                    end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        timeout_err        <= 1'b1;
                        done               <= 1'b1;
                        core.core_data_rdy <= 2'b00;
                        state              <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    // bit_cnt == i-1 while sampling ciphertext bit i
                    if (!core.core_valid) begin
                        timeout_err        <= 1'b1;
                        done               <= 1'b1;
                        core.core_data_rdy <= 2'b00;
                        state              <= S_DONE;
                    end else if (bit_cnt == CW'(BLOCK_BITS - 2)) begin
                        ct                 <= {core.core_cipher_out,
                                               cap[BLOCK_BITS-1:1]};
                        done               <= 1'b1;
                        core.core_data_rdy <= 2'b00;
                        state              <= S_DONE;
                    end else begin
                        cap     <= {core.core_cipher_out, cap[BLOCK_BITS-1:1]};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    busy               <= 1'b0;
                    core.core_data_rdy <= 2'b00;
                    state              <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_host_serial.sv
// tb_simon_host_serial: self-checking bench for simon_host_serial with a
// behavioural core model driving core_valid/core_cipher_out.
module tb_simon_host_serial;

    localparam int BB = 128;
    localparam int KB = 128;
    localparam int TO = 16;

    typedef struct {
        logic [BB-1:0] pt;
        logic [KB-1:0] key;
        logic [BB-1:0] ctv;
        int            lat;
        int            abort;
        bit            glitch;
        bit            hold;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BB-1:0] pt;
    logic [KB-1:0] key;
    logic          busy;
    logic          done;
    logic [BB-1:0] ct;
    logic          timeout_err;

    simon_host_serial_if cif ();

    simon_host_serial #(
        .BLOCK_BITS (BB),
        .KEY_BITS   (KB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pt         (pt),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ct         (ct),
        .timeout_err(timeout_err),
        .core       (cif.master)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    logic [BB-1:0] ref_ct;
    logic          ref_terr;

    task automatic chk(input string name, input logic [BB-1:0] act,
                       input logic [BB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BB-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full operation; entered and left at a falling edge in IDLE.
    task automatic op(input vec_t v);
        logic [BB-1:0] got_pt;
        logic [KB-1:0] got_key;
        bit            rdy_ok;
        bit            quiet;
        bit            ok;
        int            exp_off;
        int            j;
        start = 1'b1;
        pt    = v.pt;
        key   = v.key;
        @(posedge clk);
        @(negedge clk);
        start = v.hold;
        chk("terr_clr", BB'(timeout_err), BB'(0));
        ref_terr = 1'b0;
        rdy_ok = 1'b1;
        got_pt = '0;
        for (int i = 0; i < BB; i++) begin
            if (i > 0) @(negedge clk);
            got_pt[i] = cif.core_data_in;
            if (cif.core_data_rdy !== 2'b01 || busy !== 1'b1 || done !== 1'b0)
                rdy_ok = 1'b0;
            if (v.glitch && i == 50) begin
                start = 1'b1;
                pt    = ~v.pt;
                key   = ~v.key;
            end else begin
                start = v.hold;
            end
        end
        chk("pt_ser", got_pt, v.pt);
        chk("pt_rdy", BB'(rdy_ok), BB'(1));
        rdy_ok  = 1'b1;
        got_key = '0;
        for (int i = 0; i < KB; i++) begin
            @(negedge clk);
            got_key[i] = cif.core_data_in;
            if (cif.core_data_rdy !== 2'b10 || busy !== 1'b1 || done !== 1'b0)
                rdy_ok = 1'b0;
        end
        chk("key_ser", got_key, v.key);
        chk("key_rdy", BB'(rdy_ok), BB'(1));
        ok = (v.lat >= 0 && v.lat < TO) && (v.abort <= 0);
        if (v.lat < 0 || v.lat >= TO) exp_off = TO;
        else if (v.abort > 0) exp_off = v.lat + v.abort + 1;
        else exp_off = v.lat + BB;
        rdy_ok = 1'b1;
        quiet  = 1'b1;
        for (int r = 0; r < exp_off; r++) begin
            @(negedge clk);
            if (cif.core_data_rdy !== 2'b11 || busy !== 1'b1 ||
                cif.core_data_in !== 1'b0)
                rdy_ok = 1'b0;
            if (done !== 1'b0) quiet = 1'b0;
            if (v.lat >= 0 && r >= v.lat) begin
                j = r - v.lat;
                cif.core_valid      = !(v.abort > 0 && j >= v.abort);
                cif.core_cipher_out = v.ctv[j];
            end else begin
                cif.core_valid      = 1'b0;
                cif.core_cipher_out = $urandom_range(1);
            end
            start = v.hold || (v.glitch && (r == 2 || r == v.lat + 10));
        end
        @(negedge clk);
        cif.core_valid = 1'b0;
        start = v.hold;
        chk("run_rdy", BB'(rdy_ok), BB'(1));
        chk("run_quiet", BB'(quiet), BB'(1));
        chk("done_hi", BB'({done, busy, cif.core_data_rdy}), BB'(4'b1100));
        if (ok) ref_ct = v.ctv;
        else ref_terr = 1'b1;
        chk("ct", ct, ref_ct);
        chk("terr", BB'(timeout_err), BB'(ref_terr));
        @(negedge clk);
        chk("idle", BB'({done, busy, cif.core_data_rdy}), BB'(0));
    endtask

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pt    = '0;
        key   = '0;
        cif.core_valid      = 1'b0;
        cif.core_cipher_out = 1'b0;
        ref_ct   = '0;
        ref_terr = 1'b0;

        tbl.push_back('{128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                        rnd128(), 0, -1, 1'b0, 1'b0});
        tbl.push_back('{128'h63736564207372656c6c657661727420,
                        128'h0f0e0d0c0b0a09080706050403020100,
                        128'h49681b1e1e54fe3f65aa832af84e0bbc, 5, -1, 1'b0, 1'b0});
        tbl.push_back('{rnd128(), rnd128(), rnd128(), -1, -1, 1'b0, 1'b0});
        tbl.push_back('{rnd128(), rnd128(), rnd128(), TO - 1, -1, 1'b0, 1'b0});
        tbl.push_back('{rnd128(), rnd128(), rnd128(), 3, 40, 1'b0, 1'b0});
        tbl.push_back('{rnd128(), rnd128(), rnd128(), 4, -1, 1'b1, 1'b0});
        tbl.push_back('{rnd128(), rnd128(), rnd128(), 1, -1, 1'b0, 1'b1});
        tbl.push_back('{rnd128(), rnd128(), rnd128(), 2, -1, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{rnd128(), rnd128(), rnd128(),
                            int'($urandom_range(20)) - 1,
                            ($urandom_range(1) == 1) ? int'($urandom_range(127, 1)) : -1,
                            1'(($urandom_range(1))), 1'b0});

        repeat (2) @(negedge clk);
        chk("rst_state",
            BB'({busy, done, timeout_err, cif.core_data_in, cif.core_data_rdy}),
            BB'(0));
        chk("rst_ct", ct, BB'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) op(tbl[i]);

        // make ct nonzero, then reset in the middle of LOAD_KEY
        op('{rnd128() | 128'h1, rnd128(), rnd128() | 128'h1, 0, -1, 1'b0, 1'b0});
        start = 1'b1;
        pt    = rnd128();
        key   = rnd128();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (BB + 20) @(negedge clk);
        chk("pre_rst_rdy", BB'(cif.core_data_rdy), BB'(2'b10));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst", BB'({busy, done, cif.core_data_rdy}), BB'(0));
        chk("mid_rst_ct", ct, BB'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_ct   = '0;
        ref_terr = 1'b0;
        @(negedge clk);
        chk("post_rst", BB'({busy, done, timeout_err, cif.core_data_rdy}),
            BB'(0));
        op('{rnd128(), rnd128(), rnd128(), 6, -1, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/simon_host_serial.md
# simon_host_serial

Parallel-to-serial host adapter for the bit-serial SIMON 128/128 core (`simon_module`).
- Accepts a parallel plaintext and key with a start pulse.
- Streams both into the core over `data_in`/`data_rdy`, then commands encryption.
- Waits for the core's `valid`, deserialises `cipher_out` into a parallel ciphertext register, and signals completion.
- Sits between the chip-level register/pin interface and the cipher core.

## Interface
- `BLOCK_BITS`, 128, plaintext/ciphertext width (bits streamed per block)
- `KEY_BITS`, 128, key width (bits streamed per key)
- `TIMEOUT_CYC`, 8192, max cycles in RUN waiting for `core_valid`; counter width is $clog2(TIMEOUT_CYC+1)
- `clk`  in  1  system clock; one clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request encryption; sampled only in IDLE
- `pt`  in  BLOCK_BITS  plaintext, latched on accepted start
- `key`  in  KEY_BITS  key, latched on accepted start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of operation (success or timeout)
- `ct`  out  BLOCK_BITS  captured ciphertext, held until the next successful completion
- `timeout_err`  out  1  sticky; set on timeout or capture abort, cleared on accepted start
- `core_data_in`  out  1  serial bit to core `data_in`
- `core_data_rdy`  out  2  core command: 00 idle, 01 load plaintext bit, 10 load key bit, 11 encrypt/run
- `core_debug_port`  out  1  tied 0 (cipher output selected)
- `core_cipher_out`  in  1  serial ciphertext bit from core
- `core_valid`  in  1  core ciphertext-valid flag

## Operation
- Reset values:
  - FSM = IDLE.
  - `busy`, `done`, `timeout_err`, `core_data_in`, `core_data_rdy` = 0.
  - `ct` = 0.
  - Bit and timeout counters = 0.
- States: IDLE, LOAD_PT, LOAD_KEY, RUN, CAPTURE, DONE.
- IDLE:
  - `start=1` latches `pt` and `key` into shift registers, clears `timeout_err`, and moves to LOAD_PT.
  - `start` in any other state is ignored.
- LOAD_PT:
  - `core_data_rdy=01`, `core_data_in=pt_sr[0]`; shift right every cycle.
  - Exactly BLOCK_BITS cycles, then LOAD_KEY.
- LOAD_KEY:
  - `core_data_rdy=10`, `core_data_in=key_sr[0]`, LSB first.
  - Exactly KEY_BITS cycles, then RUN.
- RUN:
  - `core_data_rdy=11`, `core_data_in=0`; timeout counter increments each cycle.
  - If `core_valid=1`: sample `core_cipher_out` into capture bit 0 and go to CAPTURE.
  - Else, if the counter reaches TIMEOUT_CYC: set `timeout_err` and go to DONE.
  - `core_valid` takes priority if both conditions occur in the same cycle.
- CAPTURE:
  - `core_data_rdy` stays 11.
  - Samples `core_cipher_out` LSB-first into `cap[i]` for i = 1..BLOCK_BITS-1, one bit per cycle.
  - If `core_valid=0` in any CAPTURE cycle: set `timeout_err`, leave `ct` unchanged, go to DONE.
  - After the last bit: `ct <= cap` (complete word), go to DONE.
- DONE:
  - `done=1` for exactly one cycle, `core_data_rdy=00`, then IDLE.
  - `busy` drops in the same cycle IDLE is entered.
- Counters are sized for the max of BLOCK_BITS and KEY_BITS; they reset to 0 on every state entry, with no wrap within a state.
- Reset mid-operation: next edge returns all state to reset values. `ct` is cleared and `core_data_rdy=00` immediately, so the core sees no partial command continuation.

## Timing
- Accepted start sampled at edge k.
- Cycles k+1..k+BLOCK_BITS: plaintext bits 0..BLOCK_BITS-1 on `core_data_in`, `core_data_rdy=01`.
- Next KEY_BITS cycles: key bits 0..KEY_BITS-1 on `core_data_in`, `core_data_rdy=10`.
- From cycle k+BLOCK_BITS+KEY_BITS+1: `core_data_rdy=11`.
- Capture and completion:
  - First `core_valid=1` at cycle v: bit 0 is captured at v, bit BLOCK_BITS-1 at v+BLOCK_BITS-1.
  - `done` is high and `ct` is updated in cycle v+BLOCK_BITS.
- Timeout case: `done` is high in cycle k+BLOCK_BITS+KEY_BITS+TIMEOUT_CYC+1.
- Back-to-back operation: `start` held high through `done` is accepted on the first IDLE cycle after DONE; minimum one IDLE cycle between operations.
- All outputs are registered; there is no combinational path from core inputs to host outputs.

## Test plan
- Reset behaviour: assert `reset` for 3 cycles mid-LOAD_KEY -> next cycle `busy=0`, `core_data_rdy=00`, `ct=0`, `done=0`. A subsequent start runs a full clean sequence.
- Serialisation order: `pt=0x...0001`, `key=0x8000...0000`, behavioural core monitor.
  - Required: 128 cycles of `data_rdy=01` with `data_in=1` only in the first cycle.
  - Then 128 cycles of `data_rdy=10` with `data_in=1` only in the last cycle.
  - Then `data_rdy=11`.
- End to end with real `simon_module`:
  - key=0x0f0e0d0c0b0a09080706050403020100, pt=0x63736564207372656c6c657661727420.
  - Required: `ct`=0x49681b1e1e54fe3f65aa832af84e0bbc, `done` single pulse, `timeout_err=0`.
- Timeout: core model never asserts valid, TIMEOUT_CYC=16 -> `done` at cycle k+273, `timeout_err=1`, `ct` unchanged. Next accepted `start` clears `timeout_err`.
- Capture abort: model drops `core_valid` after 40 bits -> `timeout_err=1`, `done` pulse, `ct` retains previous value.
- Start gating: `start` pulsed during LOAD_PT, RUN and CAPTURE -> ignored, no re-latch of `pt`/`key`. `start` held high continuously -> two consecutive operations separated by exactly one IDLE cycle.
